// File: rtl/dir_sharer_tracker.sv
// Directory sharer-set tracker: presence vector plus an invalidate sequencer for exclusive requests.
// Optional DIR_INV_COUNT_EN adds a saturating inv_count output counting invalidate handshakes.
module dir_sharer_tracker #(
  parameter int NODES  = 8,
  parameter int NODE_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soma,
  input  logic              excl,
  input  logic              clear,
  input  logic [NODE_W-1:0] node,
  output logic              cmd_ready,
  output logic [NODES-1:0]  sharers,
  output logic [3:0]        sharer_count,
  output logic              msg_valid,
  input  logic              msg_ready,
  output logic [21:0]       msg,
  output logic              overflow
`ifdef DIR_INV_COUNT_EN
  ,
  output logic [7:0]        inv_count
`endif
);

  typedef enum logic {IDLE, INV} state_t;

  localparam logic [5:0] OP_INV = 6'b000100;

  state_t             state, state_n;
  logic [NODES-1:0]   pending;
  logic [NODES-1:0]   node_oh;
  logic [NODES-1:0]   excl_pend;
  logic [NODES-1:0]   dest_oh;
  logic [NODES-1:0]   pend_left;
  logic [NODE_W-1:0]  dest;
  logic               hs;
  logic               any_cmd;

  for (genvar g = 0; g < NODES; g++) begin : g_oh
    assign node_oh[g] = (node == NODE_W'(g));
  end

  assign excl_pend = sharers & ~node_oh;
  assign dest_oh   = pending & (~pending + 1'b1);
  assign pend_left = pending & ~dest_oh;
  assign hs        = msg_valid & msg_ready;
  assign any_cmd   = soma | excl | clear;

  always_comb begin
    dest = '0;
    for (int i = NODES - 1; i >= 0; i--)
      if (pending[i]) dest = NODE_W'(i);
  end

  always_comb begin
    sharer_count = '0;
    for (int i = 0; i < NODES; i++)
      sharer_count = sharer_count + 4'(sharers[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (!clear && excl && (excl_pend != '0)) state_n = INV;
      INV:  if (hs && (pend_left == '0))             state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    msg_valid = (state == INV);
    msg       = '0;
    if (msg_valid) begin
      msg[21:16]       = OP_INV;
      msg[NODE_W-1:0]  = dest;
    end
  end

  // Commands are only sampled in IDLE; during INV they only raise overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      sharers  <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (clear) begin
          sharers <= '0;
        end else if (excl) begin
          pending <= excl_pend;
          sharers <= node_oh;
        end else if (soma) begin
          sharers <= sharers | node_oh;
        end
      end else if (hs) begin
        pending <= pend_left;
      end
      if (!cmd_ready && any_cmd) overflow <= 1'b1;
    end
  end

`ifdef DIR_INV_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset)                        inv_count <= '0;
    else if (hs && inv_count != 8'hFF) inv_count <= inv_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_dir_sharer_tracker.sv
// Directed-vector bench for dir_sharer_tracker; inv_count is exercised when DIR_INV_COUNT_EN is defined.
module tb_dir_sharer_tracker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        soma = 1'b0, excl = 1'b0, clear = 1'b0;
  logic [2:0]  node = '0;
  logic        cmd_ready;
  logic [7:0]  sharers;
  logic [3:0]  sharer_count;
  logic        msg_valid;
  logic        msg_ready = 1'b0;
  logic [21:0] msg;
  logic        overflow;
`ifdef DIR_INV_COUNT_EN
  logic [7:0]  inv_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [21:0] MSG_D0 = 22'h040000;
  localparam logic [21:0] MSG_D5 = 22'h040005;

  dir_sharer_tracker #(.NODES(8), .NODE_W(3)) dut (
    .clock(clock), .reset(reset), .soma(soma), .excl(excl), .clear(clear),
    .node(node), .cmd_ready(cmd_ready), .sharers(sharers),
    .sharer_count(sharer_count), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg(msg), .overflow(overflow)
`ifdef DIR_INV_COUNT_EN
    , .inv_count(inv_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    soma = 0; excl = 0; clear = 0; msg_ready = 0;
    reset = 1; tick(); reset = 0;
  endtask

  task automatic add(input logic [2:0] n);
    soma = 1; node = n; tick(); soma = 0;
  endtask

  task automatic setup_0_2_5();
    do_reset(); add(0); add(2); add(5);
  endtask

  task automatic test_reset();
    soma = 1; node = 3; tick();
    soma = 0; do_reset();
    n_checks++; if (sharers !== 8'h00) begin n_fail++; $display("FAIL reset_sharers got %h want 00", sharers); end
    n_checks++; if (sharer_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", sharer_count); end
    n_checks++; if (msg_valid !== 1'b0 || msg !== 22'h0) begin n_fail++; $display("FAIL reset_msg got v=%b msg=%h want 0/0", msg_valid, msg); end
    n_checks++; if (overflow !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_flags got ovf=%b rdy=%b want 0/1", overflow, cmd_ready); end
`ifdef DIR_INV_COUNT_EN
    n_checks++; if (inv_count !== 8'd0) begin n_fail++; $display("FAIL reset_inv_count got %0d want 0", inv_count); end
`endif
  endtask

  task automatic test_soma();
    logic [2:0] seq [3] = '{3'd2, 3'd5, 3'd2};
    logic [7:0] exp_s [3] = '{8'h04, 8'h24, 8'h24};
    logic [3:0] exp_c [3] = '{4'd1, 4'd2, 4'd2};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      add(seq[i]);
      n_checks++; if (sharers !== exp_s[i] || sharer_count !== exp_c[i])
        begin n_fail++; $display("FAIL soma_%0d got %b/%0d want %b/%0d", i, sharers, sharer_count, exp_s[i], exp_c[i]); end
      n_checks++; if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL soma_novalid_%0d got %b want 0", i, msg_valid); end
    end
  endtask

  task automatic test_excl_stream();
    setup_0_2_5();
    msg_ready = 1; excl = 1; node = 2; tick(); excl = 0;
    n_checks++; if (sharers !== 8'b00000100 || sharer_count !== 4'd1) begin n_fail++; $display("FAIL excl_sharers got %b/%0d want 00000100/1", sharers, sharer_count); end
    n_checks++; if (msg_valid !== 1'b1 || msg !== MSG_D0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL excl_msg0 got v=%b msg=%h rdy=%b want 1/%h/0", msg_valid, msg, cmd_ready, MSG_D0); end
    tick();
    n_checks++; if (msg_valid !== 1'b1 || msg !== MSG_D5) begin n_fail++; $display("FAIL excl_msg5 got v=%b msg=%h want 1/%h", msg_valid, msg, MSG_D5); end
    tick();
    n_checks++; if (msg_valid !== 1'b0 || msg !== 22'h0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL excl_done got v=%b msg=%h rdy=%b want 0/0/1", msg_valid, msg, cmd_ready); end
`ifdef DIR_INV_COUNT_EN
    n_checks++; if (inv_count !== 8'd2) begin n_fail++; $display("FAIL excl_inv_count got %0d want 2", inv_count); end
`endif
    msg_ready = 0;
  endtask

  task automatic test_backpressure();
    setup_0_2_5();
    msg_ready = 0; excl = 1; node = 2; tick(); excl = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (msg_valid !== 1'b1 || msg !== MSG_D0) begin n_fail++; $display("FAIL bp_hold_%0d got v=%b msg=%h want 1/%h", i, msg_valid, msg, MSG_D0); end
      if (i < 2) tick();
    end
    msg_ready = 1; tick();
    n_checks++; if (msg_valid !== 1'b1 || msg !== MSG_D5) begin n_fail++; $display("FAIL bp_msg5 got v=%b msg=%h want 1/%h", msg_valid, msg, MSG_D5); end
    tick();
    n_checks++; if (msg_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_done got v=%b rdy=%b want 0/1", msg_valid, cmd_ready); end
    msg_ready = 0;
  endtask

  task automatic test_overflow();
    setup_0_2_5();
    msg_ready = 0; excl = 1; node = 2; tick(); excl = 0;
    soma = 1; node = 7; tick(); soma = 0;
    n_checks++; if (sharers !== 8'b00000100 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b ovf=%b want 00000100/1", sharers, overflow); end
    n_checks++; if (msg_valid !== 1'b1 || msg !== MSG_D0) begin n_fail++; $display("FAIL ovf_msg_kept got v=%b msg=%h want 1/%h", msg_valid, msg, MSG_D0); end
    msg_ready = 1; tick(); tick(); msg_ready = 0;
    add(1);
    n_checks++; if (overflow !== 1'b1 || sharers !== 8'b00000110) begin n_fail++; $display("FAIL ovf_sticky got ovf=%b sh=%b want 1/00000110", overflow, sharers); end
    do_reset();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_reset got %b want 0", overflow); end
  endtask

  task automatic test_priority();
    do_reset();
    for (int i = 0; i < 8; i++) add(3'(i));
    n_checks++; if (sharers !== 8'hFF || sharer_count !== 4'd8) begin n_fail++; $display("FAIL prio_full got %h/%0d want ff/8", sharers, sharer_count); end
    clear = 1; excl = 1; soma = 1; node = 3; tick();
    clear = 0; excl = 0; soma = 0;
    n_checks++; if (sharers !== 8'h00 || msg_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL prio_clear got %h v=%b rdy=%b want 00/0/1", sharers, msg_valid, cmd_ready); end
    tick();
    n_checks++; if (msg_valid !== 1'b0 || sharer_count !== 4'd0) begin n_fail++; $display("FAIL prio_quiet got v=%b cnt=%0d want 0/0", msg_valid, sharer_count); end
  endtask

  task automatic test_excl_no_pending();
    do_reset(); add(4);
    excl = 1; node = 4; tick(); excl = 0;
    n_checks++; if (sharers !== 8'b00010000 || msg_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL excl_self got %b v=%b rdy=%b want 00010000/0/1", sharers, msg_valid, cmd_ready); end
    do_reset();
    excl = 1; node = 3; tick(); excl = 0;
    n_checks++; if (sharers !== 8'b00001000 || msg_valid !== 1'b0) begin n_fail++; $display("FAIL excl_empty got %b v=%b want 00001000/0", sharers, msg_valid); end
  endtask

  task automatic test_reset_mid_inv();
    setup_0_2_5();
    msg_ready = 0; excl = 1; node = 2; tick(); excl = 0;
    n_checks++; if (msg_valid !== 1'b1) begin n_fail++; $display("FAIL rmi_enter got v=%b want 1", msg_valid); end
    msg_ready = 1; reset = 1; tick(); reset = 0;
    n_checks++; if (msg_valid !== 1'b0 || sharers !== 8'h00 || msg !== 22'h0) begin n_fail++; $display("FAIL rmi_abort got v=%b sh=%h msg=%h want 0/00/0", msg_valid, sharers, msg); end
    tick();
    n_checks++; if (msg_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmi_after got v=%b rdy=%b want 0/1", msg_valid, cmd_ready); end
    msg_ready = 0;
  endtask

`ifdef DIR_INV_COUNT_EN
  task automatic test_inv_count();
    int waited;
    do_reset();
    msg_ready = 1;
    for (int r = 0; r < 43; r++) begin
      msg_ready = 0;
      for (int n = 1; n < 8; n++) add(3'(n));
      msg_ready = 1; excl = 1; node = 0; tick(); excl = 0;
      waited = 0;
      while (!cmd_ready && waited < 16) begin tick(); waited++; end
      if (!cmd_ready) begin
        n_checks++; n_fail++; $display("FAIL cnt_drain_timeout round %0d rdy=%b want 1", r, cmd_ready);
        break;
      end
      if (r == 0) begin
        n_checks++; if (inv_count !== 8'd7) begin n_fail++; $display("FAIL cnt_round0 got %0d want 7", inv_count); end
      end
      if (r == 35) begin
        n_checks++; if (inv_count !== 8'd252) begin n_fail++; $display("FAIL cnt_252 got %0d want 252", inv_count); end
      end
    end
    n_checks++; if (inv_count !== 8'd255) begin n_fail++; $display("FAIL cnt_saturate got %0d want 255", inv_count); end
    msg_ready = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_soma();
    test_excl_stream();
    test_backpressure();
    test_overflow();
    test_priority();
    test_excl_no_pending();
    test_reset_mid_inv();
`ifdef DIR_INV_COUNT_EN
    test_inv_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
